rv_boot_sequencer: RTL and testbench
====================================

Name: rv_boot_sequencer

Overview:
- Parametrised reset/boot controller for the RISC-V core; supersedes fixed-delay reset and read-enable stimulus.
- Holds the core in reset for a programmable number of cycles and enables instruction-memory reads.
- Runs the core and detects termination: explicit halt, PC self-loop, or cycle-budget timeout.
- Sits between top-level/bench control and the core's reset and imem_read_en inputs.

Parameters:
XLEN, 32, PC width
CNT_W, 32, cycle counter width
RESET_CYCLES, 1, cycles core_reset held in RESET_HOLD; legal range 1..255
MAX_CYCLES, 10, RUN-cycle budget before timeout; legal range 1..2^CNT_W-1
STALL_LIMIT, 4, consecutive repeated-PC compares that declare a self-loop halt; 0 disables
AUTO_START, 1, 1 = leave IDLE automatically after reset without start

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
start  input  1  pulse: begin or restart a boot; honoured in IDLE and DONE only
core_halt  input  1  core-reported halt (ecall/ebreak); sampled in RUN only
pc  input  XLEN  core program counter
core_reset  output  1  reset to core, active-high
imem_read_en  output  1  instruction-memory read enable
running  output  1  high in RUN
done  output  1  sticky termination flag
halt_cause  output  2  0 none, 1 core_halt, 2 pc_stall, 3 timeout
cycle_count  output  CNT_W  RUN cycles elapsed

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Registered outputs: all outputs are registered and decoded from the state register; no combinational input-to-output path.
- Reset values: state=IDLE, core_reset=1, imem_read_en=0, running=0, done=0, halt_cause=0, cycle_count=0, hold_cnt=0, stall_cnt=0, pc_valid=0.
- IDLE:
  - core_reset=1, imem_read_en=0.
  - Go to RESET_HOLD on start, or on the first post-reset cycle if AUTO_START=1.
- RESET_HOLD:
  - core_reset=1, imem_read_en=1.
  - hold_cnt counts 0..RESET_CYCLES-1, then go to RUN.
  - If start is sampled in IDLE at edge t, RESET_HOLD occupies cycles t+1..t+RESET_CYCLES.
  - core_reset first reads 0 at cycle t+RESET_CYCLES+1.
- RUN:
  - core_reset=0, imem_read_en=1, running=1.
  - cycle_count increments by 1 every RUN cycle.
  - Stall detection: pc_prev<=pc every cycle; pc_valid set after the first RUN cycle.
    - stall_cnt increments when pc_valid && pc==pc_prev, otherwise clears.
    - Stall halt when stall_cnt reaches STALL_LIMIT, i.e. PC unchanged across STALL_LIMIT+1 consecutive samples.
- Exit from RUN to DONE, evaluated each RUN cycle in priority order:
  - core_halt -> cause 1.
  - Stall halt -> cause 2.
  - The incremented count equals MAX_CYCLES -> cause 3.
  - Simultaneous events: the highest priority wins and only that cause is recorded.
- Terminating RUN cycle: counted, so cycle_count in DONE equals the number of RUN cycles executed.
- DONE:
  - core_reset=1, imem_read_en=0, running=0, done=1.
  - halt_cause and cycle_count frozen.
  - start in DONE: clear done, halt_cause, cycle_count, stall_cnt and pc_valid; go to RESET_HOLD. No IDLE pass and no AUTO_START re-trigger.
- start in RESET_HOLD or RUN: ignored.
- reset mid-operation: any state returns to IDLE with reset values next cycle; the core sees core_reset=1 immediately after that edge.
- Counter width: cycle_count never wraps, because MAX_CYCLES < 2^CNT_W.
- Elaboration checks: a parameter assertion rejects RESET_CYCLES=0 and MAX_CYCLES=0.

Decomposition:
- Package rv_bench_pkg:
  - boot_state_e (IDLE, RESET_HOLD, RUN, DONE).
  - halt_cause_e (NONE, CORE_HALT, PC_STALL, TIMEOUT), 2-bit.
- Sub-module rv_stall_detector (params XLEN, STALL_LIMIT):
  - Holds pc_prev, pc_valid and stall_cnt.
  - Inputs clk, reset, clear, enable, pc; output stall.
  - When STALL_LIMIT=0 it ties stall to 0.

Test Plan:
- Defaults (RESET_CYCLES=1, MAX_CYCLES=10, STALL_LIMIT=4, AUTO_START=1); reset high 1 cycle, then low; pc increments by 4 each cycle, core_halt=0:
  - core_reset high for exactly 2 cycles after reset drops (IDLE, then RESET_HOLD).
  - imem_read_en rises in RESET_HOLD.
  - running high 10 cycles; then done=1, halt_cause=3, cycle_count=10, core_reset=1, imem_read_en=0.
- RESET_CYCLES=5, AUTO_START=0; start pulsed at cycle 3:
  - IDLE persists until start.
  - core_reset stays high through cycle 8 and reads 0 at cycle 9.
- MAX_CYCLES=100; pc advances for 6 RUN cycles, then holds 0x0000_0018:
  - done after the 5th identical sample.
  - halt_cause=2, cycle_count=11.
  - With STALL_LIMIT=0 the same stimulus gives halt_cause=3, cycle_count=100.
- MAX_CYCLES=10; core_halt asserted in RUN cycle 10 while pc is stalled:
  - halt_cause=1, cycle_count=10; priority over stall and timeout.
- Reset asserted in RUN cycle 4:
  - Next cycle: state IDLE, core_reset=1, cycle_count=0, done=0.
  - AUTO_START re-boots afterwards.
- After DONE, start pulse:
  - Flags and count clear; RESET_HOLD entered directly.
  - A second run completes normally.
  - start pulsed during RUN is ignored, with no count reset.

Source files
------------

// File: rtl/rv_bench_pkg.sv
// Shared types for the boot sequencer: FSM states, termination causes
// and the width of the reset-hold counter.
package rv_bench_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } boot_state_e;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    CORE_HALT = 2'd1,
    PC_STALL  = 2'd2,
    TIMEOUT   = 2'd3
  } halt_cause_e;

  // RESET_CYCLES is limited to 1..255, so 8 bits cover the hold counter
  localparam int HOLD_W = 8;

endpackage

// File: rtl/rv_stall_detector.sv
// PC self-loop detector. Tracks the previous PC and counts consecutive
// repeated samples while enabled; flags a stall on the cycle the repeat
// count reaches STALL_LIMIT (STALL_LIMIT+1 identical samples).
// STALL_LIMIT = 0 disables detection entirely.
module rv_stall_detector
  import rv_bench_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STALL_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [XLEN-1:0] pc,
  output logic            stall
);

  // Wide enough to hold STALL_LIMIT itself; at least one bit when disabled
  localparam int SW = $clog2(STALL_LIMIT + 2);
  localparam logic [SW-1:0] LIM = SW'(STALL_LIMIT);

  logic [XLEN-1:0] pc_prev_q;
  logic            pc_valid_q;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [SW-1:0]   cnt_inc;
  logic            match;

  // Next repeat count: grows on a repeated PC, saturates at the limit,
  // and restarts whenever the PC moves
  always_comb begin
    match       = enable && pc_valid_q && (pc == pc_prev_q);
    cnt_inc     = stall_cnt_q + 1'b1;
    stall_cnt_d = '0;
    if (match) stall_cnt_d = (stall_cnt_q == LIM) ? stall_cnt_q : cnt_inc;
  end

  // The stall is reported combinationally on the hitting sample so the
  // sequencer can terminate in that same RUN cycle
  assign stall = (STALL_LIMIT != 0) && match && (cnt_inc == LIM);

  // PC history; cleared on reset and at the start of every boot
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pc_prev_q   <= '0;
      pc_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else if (enable) begin
      pc_prev_q   <= pc;
      pc_valid_q  <= 1'b1;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: rtl/rv_boot_sequencer.sv
// Boot/reset controller for the RISC-V core. Holds the core in reset for
// RESET_CYCLES, then runs it with instruction fetch enabled until it halts,
// self-loops on a PC, or exhausts MAX_CYCLES. All outputs are registered.
module rv_boot_sequencer
  import rv_bench_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          CNT_W        = 32,
  parameter int          RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 10,
  parameter int          STALL_LIMIT  = 4,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             core_halt,
  input  logic [XLEN-1:0]  pc,
  output logic             core_reset,
  output logic             imem_read_en,
  output logic             running,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count
);

  // Elaboration-time parameter sanity
  if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
    $error("rv_boot_sequencer: RESET_CYCLES must be in 1..255");
  end
  if (MAX_CYCLES == 0) begin : g_bad_max_cycles
    $error("rv_boot_sequencer: MAX_CYCLES must be nonzero");
  end
  if ((64'(MAX_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_cnt_w
    $error("rv_boot_sequencer: MAX_CYCLES must fit below 2^CNT_W");
  end

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CYCLES);

  boot_state_e       state_q;
  halt_cause_e       cause_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              auto_pend_q;
  logic              core_reset_q, imem_read_en_q, running_q, done_q;
  logic [CNT_W-1:0]  cycle_count_q;

  logic              idle_go;
  logic              det_clear;
  logic              det_en;
  logic              stall;
  logic [CNT_W-1:0]  cnt_inc;

  // Boot triggers and stall-detector control. auto_pend_q arms a single
  // automatic boot per reset; a restart from DONE never uses it.
  always_comb begin
    idle_go   = start || (AUTO_START && auto_pend_q);
    det_clear = ((state_q == IDLE) && idle_go) || ((state_q == DONE) && start);
    det_en    = (state_q == RUN);
    cnt_inc   = cycle_count_q + 1'b1;
  end

  rv_stall_detector #(
    .XLEN        (XLEN),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk    (clk),
    .reset  (reset),
    .clear  (det_clear),
    .enable (det_en),
    .pc     (pc),
    .stall  (stall)
  );

  // Boot FSM with registered outputs updated on every state transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cause_q        <= NONE;
      hold_cnt_q     <= '0;
      auto_pend_q    <= 1'b1;
      core_reset_q   <= 1'b1;
      imem_read_en_q <= 1'b0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_go) begin
            state_q        <= RESET_HOLD;
            hold_cnt_q     <= '0;
            auto_pend_q    <= 1'b0;
            core_reset_q   <= 1'b1;
            imem_read_en_q <= 1'b1;
          end
        end

        RESET_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= RUN;
            core_reset_q <= 1'b0;
            running_q    <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end

        RUN: begin
          // The terminating cycle is counted as well
          cycle_count_q <= cnt_inc;
          if (core_halt || stall || (cnt_inc == MAX_C)) begin
            state_q        <= DONE;
            core_reset_q   <= 1'b1;
            imem_read_en_q <= 1'b0;
            running_q      <= 1'b0;
            done_q         <= 1'b1;
            if (core_halt)  cause_q <= CORE_HALT;
            else if (stall) cause_q <= PC_STALL;
            else            cause_q <= TIMEOUT;
          end
        end

        DONE: begin
          // Restart goes straight to RESET_HOLD; cause and count are dropped
          if (start) begin
            state_q        <= RESET_HOLD;
            hold_cnt_q     <= '0;
            done_q         <= 1'b0;
            cause_q        <= NONE;
            cycle_count_q  <= '0;
            imem_read_en_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_reset   = core_reset_q;
  assign imem_read_en = imem_read_en_q;
  assign running      = running_q;
  assign done         = done_q;
  assign halt_cause   = cause_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_rv_boot_sequencer.sv
// Bench for rv_boot_sequencer. Four instances cover the parameter sets:
//   0: defaults (timeout, halt priority, restart, mid-run reset)
//   1: RESET_CYCLES=5, AUTO_START=0 (start-triggered boot)
//   2: MAX_CYCLES=100 (PC self-loop)
//   3: MAX_CYCLES=100, STALL_LIMIT=0 (same stimulus, times out)
// Expected output snapshots are queued with the edge count after which they
// must hold; the monitor samples on the falling edge and retires them.
module tb_rv_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [4];
  logic        start_v [4];
  logic        halt_v  [4];
  logic [31:0] pc_v    [4];

  logic        cr_w  [4];
  logic        im_w  [4];
  logic        run_w [4];
  logic        dn_w  [4];
  logic [1:0]  hc_w  [4];
  logic [31:0] cnt_w [4];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rv_boot_sequencer #(.XLEN(32), .CNT_W(32), .RESET_CYCLES(1), .MAX_CYCLES(10),
                      .STALL_LIMIT(4), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .core_halt(halt_v[0]), .pc(pc_v[0]),
    .core_reset(cr_w[0]), .imem_read_en(im_w[0]), .running(run_w[0]), .done(dn_w[0]),
    .halt_cause(hc_w[0]), .cycle_count(cnt_w[0]));

  rv_boot_sequencer #(.XLEN(32), .CNT_W(32), .RESET_CYCLES(5), .MAX_CYCLES(10),
                      .STALL_LIMIT(4), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .core_halt(halt_v[1]), .pc(pc_v[1]),
    .core_reset(cr_w[1]), .imem_read_en(im_w[1]), .running(run_w[1]), .done(dn_w[1]),
    .halt_cause(hc_w[1]), .cycle_count(cnt_w[1]));

  rv_boot_sequencer #(.XLEN(32), .CNT_W(32), .RESET_CYCLES(1), .MAX_CYCLES(100),
                      .STALL_LIMIT(4), .AUTO_START(1'b1)) dut_c (
    .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .core_halt(halt_v[2]), .pc(pc_v[2]),
    .core_reset(cr_w[2]), .imem_read_en(im_w[2]), .running(run_w[2]), .done(dn_w[2]),
    .halt_cause(hc_w[2]), .cycle_count(cnt_w[2]));

  rv_boot_sequencer #(.XLEN(32), .CNT_W(32), .RESET_CYCLES(1), .MAX_CYCLES(100),
                      .STALL_LIMIT(0), .AUTO_START(1'b1)) dut_d (
    .clk(clk), .reset(rst_v[3]), .start(start_v[3]), .core_halt(halt_v[3]), .pc(pc_v[3]),
    .core_reset(cr_w[3]), .imem_read_en(im_w[3]), .running(run_w[3]), .done(dn_w[3]),
    .halt_cause(hc_w[3]), .cycle_count(cnt_w[3]));

  typedef struct {
    int          id;
    int          at;
    string       nm;
    logic        cr, im, run, dn;
    logic [1:0]  hc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push(input int id, input int at, input string nm,
                      input logic cr, input logic im, input logic run, input logic dn,
                      input logic [1:0] hc, input int cnt);
    exp_t e;
    e.id = id; e.at = at; e.nm = nm;
    e.cr = cr; e.im = im; e.run = run; e.dn = dn; e.hc = hc; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    n_vec++;
    if (cr_w[e.id] !== e.cr || im_w[e.id] !== e.im || run_w[e.id] !== e.run ||
        dn_w[e.id] !== e.dn || hc_w[e.id] !== e.hc || cnt_w[e.id] !== e.cnt) begin
      n_err++;
      $display("FAIL %s @%0d: got cr=%b im=%b run=%b done=%b cause=%0d cnt=%0d, want cr=%b im=%b run=%b done=%b cause=%0d cnt=%0d",
               e.nm, e.at, cr_w[e.id], im_w[e.id], run_w[e.id], dn_w[e.id], hc_w[e.id], cnt_w[e.id],
               e.cr, e.im, e.run, e.dn, e.hc, e.cnt);
    end
  endtask

  // Monitor: retire every expectation due at the current edge count
  always @(negedge clk) begin : monitor
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", sb[i].nm, sb[i].at, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    for (int j = 0; j < 4; j++) begin
      rst_v[j] = 1'b1; start_v[j] = 1'b0; halt_v[j] = 1'b0; pc_v[j] = '0;
    end

    //            id  at  name              cr im rn dn hc cnt
    push(0,  1, "a_reset",          1, 0, 0, 0, 0, 0);
    push(0,  2, "a_hold",           1, 1, 0, 0, 0, 0);
    push(0,  3, "a_run_first",      0, 1, 1, 0, 0, 0);
    push(0, 12, "a_run_last",       0, 1, 1, 0, 0, 9);
    push(0, 13, "a_timeout",        1, 0, 0, 1, 3, 10);
    push(0, 15, "a_done_frozen",    1, 0, 0, 1, 3, 10);
    push(0, 16, "a_restart_hold",   1, 1, 0, 0, 0, 0);
    push(0, 17, "a2_run_first",     0, 1, 1, 0, 0, 0);
    push(0, 20, "a2_start_ignored", 0, 1, 1, 0, 0, 3);
    push(0, 26, "a2_run_last",      0, 1, 1, 0, 0, 9);
    push(0, 27, "a2_halt_prio",     1, 0, 0, 1, 1, 10);
    push(0, 29, "a2_done_frozen",   1, 0, 0, 1, 1, 10);
    push(0, 30, "a3_restart_hold",  1, 1, 0, 0, 0, 0);
    push(0, 34, "a3_run4",          0, 1, 1, 0, 0, 3);
    push(0, 35, "a3_midrun_reset",  1, 0, 0, 0, 0, 0);
    push(0, 36, "a4_auto_hold",     1, 1, 0, 0, 0, 0);
    push(0, 37, "a4_run_first",     0, 1, 1, 0, 0, 0);
    push(0, 47, "a4_timeout",       1, 0, 0, 1, 3, 10);

    push(1,  1, "b_reset",          1, 0, 0, 0, 0, 0);
    push(1,  2, "b_idle_wait",      1, 0, 0, 0, 0, 0);
    push(1,  3, "b_hold_first",     1, 1, 0, 0, 0, 0);
    push(1,  7, "b_hold_last",      1, 1, 0, 0, 0, 0);
    push(1,  8, "b_run_first",      0, 1, 1, 0, 0, 0);
    push(1, 18, "b_timeout",        1, 0, 0, 1, 3, 10);

    push(2, 13, "c_before_stall",   0, 1, 1, 0, 0, 10);
    push(2, 14, "c_pc_stall",       1, 0, 0, 1, 2, 11);
    push(3, 14, "d_stall_disabled", 0, 1, 1, 0, 0, 11);
    push(3, 103, "d_timeout",       1, 0, 0, 1, 3, 100);

    // Inputs set after edge c are sampled at edge c+1
    for (int c = 1; c <= 106; c++) begin
      @(posedge clk);
      #1;
      // dut 0: reset once at start, again in RUN cycle 4 of the third run
      rst_v[0]   = (c == 34);
      start_v[0] = (c == 15) || (c == 19) || (c == 29);
      halt_v[0]  = (c == 26);
      if (c >= 17 && c <= 26) begin
        // second run: PC advances for 5 RUN cycles, then parks at 0x14
        pc_v[0] = (c - 16 <= 5) ? 32'(4 * (c - 17)) : 32'h14;
      end else begin
        pc_v[0] = pc_v[0] + 32'd4;
      end

      // dut 1: start sampled at edge 3
      rst_v[1]   = 1'b0;
      start_v[1] = (c == 2);
      pc_v[1]    = pc_v[1] + 32'd4;

      // duts 2/3: PC advances for 6 RUN cycles, then holds 0x18
      rst_v[2] = 1'b0;
      rst_v[3] = 1'b0;
      if (c - 2 <= 0)      pc_v[2] = '0;
      else if (c - 2 <= 6) pc_v[2] = 32'(4 * (c - 3));
      else                 pc_v[2] = 32'h18;
      pc_v[3] = pc_v[2];
    end

    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
      n_vec += sb.size();
      n_err += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
